mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified memory between the CPU instruction-fetch path and the load/store path, letting the SoC move from a dual-ported program memory to one physical port with multi-cycle access. Sits between the CPU core and the memory macro inside SoC. It grants one requester per transaction, sequences the fixed memory read latency, and routes the returned word back to the owner. Data accesses have priority, and an optional streak limit prevents fetch starvation.

## Interface
- ADDR_WIDTH, 32, byte-address width of all address ports
- MEM_LATENCY, 1, cycles from mem_en sampled to mem_rdata valid; legal range 1..7
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits; used only with fairness compiled in
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  ADDR_WIDTH  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  one-cycle completion pulse (loads and stores)
- d_rdata  out  32  load word; don't-care on store completion
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_rdata  in  32  memory read data

## Operation
- States: IDLE (port free), WAIT (one transaction outstanding, owner register I or D, latency counter cnt).
- Accept condition: state IDLE, or state WAIT with cnt==1 (completing this cycle).
- On accept with any req: arbitration picks owner, gnt pulses combinationally, mem_* driven combinationally from the winner, state to WAIT, cnt loaded MEM_LATENCY.
- Arbitration: d_req wins over i_req; with fairness, i_req wins if streak==MAX_D_STREAK.
- WAIT: cnt decrements each cycle; at cnt==1 owner's rvalid pulses, *_rdata = mem_rdata; next state WAIT (new accept) or IDLE.
- No accept: mem_en/mem_we=0, mem_addr/wdata/wstrb=0, both gnt=0.
- Fetch requests never write: mem_we=0, mem_wstrb=0 for I owner.
- Requester may drop req before gnt; no transaction, no rvalid.
- Non-owner rvalid always 0; i_rdata/d_rdata both follow mem_rdata (only qualified by rvalid).

## Timing
- Reset (reset==0 at clk edge): state IDLE, cnt=0, owner=D, streak=0; all outputs 0 in the following cycle and while reset low; pending response discarded, no rvalid.
- Grant latency: 0 cycles (gnt in same cycle as req when accepting).
- Response: rvalid exactly MEM_LATENCY cycles after gnt cycle.
- Throughput: one transaction per MEM_LATENCY cycles; MEM_LATENCY=1 gives back-to-back one per cycle, rvalid and next gnt in the same cycle.
- Simultaneous i_req and d_req: one gnt only, other requester waits with req held.

## Configuration
- ARB_FAIRNESS_EN defined: streak counter (3 bits) increments on each d_gnt while i_req==1, clears on i_gnt or whenever i_req==0, saturates at MAX_D_STREAK; at MAX_D_STREAK fetch wins next accept.
- Not defined: strict data priority, no streak state; fetch may starve under continuous d_req.

## Structure
- rtl/parameters.vh: state encodings ARB_IDLE/ARB_WAIT, owner encodings ARB_OWN_I/ARB_OWN_D, default MEM_LATENCY.
- One sub-module: arb_streak_counter (fairness counter, instantiated only under ARB_FAIRNESS_EN).

## Test plan
- Reset held low 3 cycles with i_req=1 -> i_gnt=0, mem_en=0, all rvalid 0; first gnt one cycle after release.
- MEM_LATENCY=1, i_req only, addresses 0,4,8 back-to-back -> i_gnt each cycle, i_rvalid 1 cycle later with memory words 0,4,8 in order.
- Both req same cycle, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_wstrb=4'b1111 -> d_gnt first, mem_we=1; i_gnt next accept; later load of 0x40 returns 0xDEADBEEF.
- MEM_LATENCY=3, fetch granted at cycle T -> i_rvalid only at T+3, no gnt at T+1/T+2, new gnt allowed at T+3.
- ARB_FAIRNESS_EN, MAX_D_STREAK=4, d_req and i_req held continuously -> grant pattern D,D,D,D,I repeating; without macro -> only D granted for 20 cycles.
- Reset asserted while in WAIT with cnt=2 -> no rvalid ever for that transaction, state IDLE after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Optional feature macro: ARB_FAIRNESS_EN (fetch anti-starvation streak limit).
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_owner_e;

    localparam int DEFAULT_MEM_LATENCY  = 1;
    localparam int DEFAULT_MAX_D_STREAK = 4;
    localparam int CNT_WIDTH            = 3;
    localparam int STREAK_WIDTH         = 3;

    // Data wins unless a fetch is waiting and has earned its turn.
    function automatic arb_owner_e pick_owner(input logic i_req,
                                              input logic d_req,
                                              input logic fetch_turn);
        if (d_req && !(i_req && fetch_turn)) begin
            return ARB_OWN_D;
        end
        return ARB_OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store paths, the arbiter and the
// memory macro. The arbiter uses the slave view; the environment the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    // fetch path
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [31:0]           i_rdata;
    // load/store path
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [31:0]           d_wdata;
    logic [3:0]            d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [31:0]           d_rdata;
    // memory macro
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );

endinterface

// File: rtl/arb_streak_counter.sv
// Counts consecutive data grants while a fetch is waiting; once the count
// reaches MAX_D_STREAK the fetch path is given the next accept slot.
module arb_streak_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic fetch_turn
);

    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_D_STREAK);

    logic [STREAK_WIDTH-1:0] streak_q;

    // Streak register: clears when the fetch is served or stops asking, saturates at the limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            streak_q <= '0;
        end else if (i_gnt || !i_req) begin
            streak_q <= '0;
        end else if (d_gnt && (streak_q != STREAK_MAX)) begin
            streak_q <= streak_q + 1'b1;
        end
    end

    assign fetch_turn = (streak_q == STREAK_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction in flight; grants are combinational in the accept slot,
// responses return MEM_LATENCY cycles later to the owning requester.
// Optional feature macro: ARB_FAIRNESS_EN (bounded data streak while fetch waits).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
    parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 7 || MAX_D_STREAK < 1 || MAX_D_STREAK > 7) begin : g_param_check
        $error("mem_port_arbiter: MEM_LATENCY and MAX_D_STREAK must be in 1..7");
    end

    arb_state_e             state_q, state_d;
    arb_owner_e             owner_q, owner_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   run_q;
    logic                   fetch_turn;
    logic                   complete;
    logic                   accept;
    arb_owner_e             winner;

`ifdef ARB_FAIRNESS_EN
    arb_streak_counter #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk        (clk),
        .reset      (reset),
        .i_req      (bus.i_req),
        .i_gnt      (bus.i_gnt),
        .d_gnt      (bus.d_gnt),
        .fetch_turn (fetch_turn)
    );
`else
    assign fetch_turn = 1'b0;
`endif

    // Arbitration, memory drive, response routing and next-state logic.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        bus.i_gnt     = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_WIDTH{1'b0}};
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;

        // run_q holds everything quiet for the first cycle after reset release.
        complete = (state_q == ARB_WAIT) && (cnt_q == CNT_WIDTH'(1));
        winner   = pick_owner(bus.i_req, bus.d_req, fetch_turn);
        accept   = reset && run_q && (bus.i_req || bus.d_req) &&
                   ((state_q == ARB_IDLE) || complete);

        bus.i_rdata = reset ? bus.mem_rdata : 32'h0;
        bus.d_rdata = reset ? bus.mem_rdata : 32'h0;

        if (reset && complete) begin
            bus.i_rvalid = (owner_q == ARB_OWN_I);
            bus.d_rvalid = (owner_q == ARB_OWN_D);
        end

        if (state_q == ARB_WAIT) begin
            cnt_d = cnt_q - 1'b1;
            if (complete) begin
                state_d = ARB_IDLE;
            end
        end

        if (accept) begin
            bus.mem_en = 1'b1;
            state_d    = ARB_WAIT;
            cnt_d      = CNT_WIDTH'(MEM_LATENCY);
            owner_d    = winner;
            if (winner == ARB_OWN_D) begin
                bus.d_gnt     = 1'b1;
                bus.mem_we    = bus.d_we;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.mem_wstrb = bus.d_wstrb;
            end else begin
                // Fetches are always reads: write enable and strobes stay zero.
                bus.i_gnt    = 1'b1;
                bus.mem_addr = bus.i_addr;
            end
        end
    end

    // State register with synchronous active-low reset; an in-flight response is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWN_D;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LATENCY=1 and one
// with MEM_LATENCY=3, each backed by a small behavioural memory.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_WIDTH(32)) bus3 ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(1), .MAX_D_STREAK(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(3), .MAX_D_STREAK(4)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models: word at byte address a initially holds value a.
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] rd1;
    logic [31:0] pipe3 [0:2];

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem1[k] = 32'(k * 4);
            mem3[k] = 32'(k * 4);
        end
    end

    always @(posedge clk) begin
        rd1 <= (bus1.mem_en && !bus1.mem_we) ? mem1[bus1.mem_addr[9:2]] : 32'h0;
        if (bus1.mem_en && bus1.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus1.mem_wstrb[b]) mem1[bus1.mem_addr[9:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
            end
        end
    end
    assign bus1.mem_rdata = rd1;

    always @(posedge clk) begin
        pipe3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr[9:2]] : 32'h0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (bus3.mem_en && bus3.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus3.mem_wstrb[b]) mem3[bus3.mem_addr[9:2]][8*b +: 8] <= bus3.mem_wdata[8*b +: 8];
            end
        end
    end
    assign bus3.mem_rdata = pipe3[2];

    // Advance to the middle of the next cycle, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus1.i_req = 1'b1;
        bus1.i_addr = 32'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            checks++; if (bus1.i_gnt !== 1'b0) begin failures++; $display("FAIL rst_i_gnt cyc=%0d got=%b exp=0", c, bus1.i_gnt); end
            checks++; if (bus1.mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en cyc=%0d got=%b exp=0", c, bus1.mem_en); end
            checks++; if ({bus1.i_rvalid, bus1.d_rvalid, bus3.i_rvalid, bus3.d_rvalid} !== 4'b0000) begin
                failures++; $display("FAIL rst_rvalid cyc=%0d got=%b exp=0000", c, {bus1.i_rvalid, bus1.d_rvalid, bus3.i_rvalid, bus3.d_rvalid});
            end
        end
        reset = 1'b1;
        #1;
        checks++; if (bus1.i_gnt !== 1'b0) begin failures++; $display("FAIL rst_release_gnt got=%b exp=0", bus1.i_gnt); end
        tick();
        #1;
        checks++; if (bus1.i_gnt !== 1'b1) begin failures++; $display("FAIL rst_first_gnt got=%b exp=1", bus1.i_gnt); end
        checks++; if (bus1.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_first_addr got=%h exp=0", bus1.mem_addr); end
        tick();
        bus1.i_req = 1'b0;
        #1;
        checks++; if (bus1.i_rvalid !== 1'b1) begin failures++; $display("FAIL rst_first_rvalid got=%b exp=1", bus1.i_rvalid); end
        checks++; if (bus1.i_rdata !== 32'h0) begin failures++; $display("FAIL rst_first_rdata got=%h exp=0", bus1.i_rdata); end
        checks++; if (bus1.d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_first_d_rvalid got=%b exp=0", bus1.d_rvalid); end
        tick();
        #1;
        checks++; if (bus1.i_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid_pulse got=%b exp=0", bus1.i_rvalid); end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] addrs [0:2];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus1.i_req = (k < 3);
            if (k < 3) bus1.i_addr = addrs[k];
            #1;
            checks++; if (bus1.i_gnt !== (k < 3)) begin failures++; $display("FAIL stream_gnt k=%0d got=%b exp=%b", k, bus1.i_gnt, (k < 3)); end
            if (k < 3) begin
                checks++; if (bus1.mem_addr !== addrs[k] || bus1.mem_we !== 1'b0) begin
                    failures++; $display("FAIL stream_mem k=%0d got addr=%h we=%b exp addr=%h we=0", k, bus1.mem_addr, bus1.mem_we, addrs[k]);
                end
            end
            checks++; if (bus1.i_rvalid !== (k > 0)) begin failures++; $display("FAIL stream_rvalid k=%0d got=%b exp=%b", k, bus1.i_rvalid, (k > 0)); end
            if (k > 0) begin
                checks++; if (bus1.i_rdata !== addrs[k-1]) begin failures++; $display("FAIL stream_rdata k=%0d got=%h exp=%h", k, bus1.i_rdata, addrs[k-1]); end
            end
        end
        tick();
        #1;
        checks++; if (bus1.i_rvalid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", bus1.i_rvalid); end
    endtask

    task automatic test_priority();
        tick();
        bus1.i_req = 1'b1; bus1.i_addr = 32'hC;
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h40;
        bus1.d_wdata = 32'hDEADBEEF; bus1.d_wstrb = 4'b1111;
        #1;
        checks++; if ({bus1.d_gnt, bus1.i_gnt} !== 2'b10) begin failures++; $display("FAIL prio_gnt got d,i=%b exp=10", {bus1.d_gnt, bus1.i_gnt}); end
        checks++; if ({bus1.mem_we, bus1.mem_wstrb, bus1.mem_addr, bus1.mem_wdata} !== {1'b1, 4'hF, 32'h40, 32'hDEADBEEF}) begin
            failures++; $display("FAIL prio_store got we=%b strb=%h addr=%h wdata=%h exp we=1 strb=f addr=40 wdata=deadbeef",
                                 bus1.mem_we, bus1.mem_wstrb, bus1.mem_addr, bus1.mem_wdata);
        end
        tick();
        bus1.d_req = 1'b0;
        #1;
        checks++; if ({bus1.i_gnt, bus1.d_rvalid, bus1.i_rvalid} !== 3'b110) begin
            failures++; $display("FAIL prio_second got i_gnt,d_rvalid,i_rvalid=%b exp=110", {bus1.i_gnt, bus1.d_rvalid, bus1.i_rvalid});
        end
        checks++; if ({bus1.mem_we, bus1.mem_wstrb, bus1.mem_addr} !== {1'b0, 4'h0, 32'hC}) begin
            failures++; $display("FAIL prio_fetch_mem got we=%b strb=%h addr=%h exp we=0 strb=0 addr=c", bus1.mem_we, bus1.mem_wstrb, bus1.mem_addr);
        end
        tick();
        bus1.i_req = 1'b0;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h40;
        #1;
        checks++; if ({bus1.i_rvalid, bus1.d_rvalid, bus1.d_gnt} !== 3'b101) begin
            failures++; $display("FAIL prio_load_gnt got i_rvalid,d_rvalid,d_gnt=%b exp=101", {bus1.i_rvalid, bus1.d_rvalid, bus1.d_gnt});
        end
        checks++; if (bus1.i_rdata !== 32'hC) begin failures++; $display("FAIL prio_fetch_rdata got=%h exp=c", bus1.i_rdata); end
        tick();
        bus1.d_req = 1'b0;
        #1;
        checks++; if ({bus1.d_rvalid, bus1.i_rvalid} !== 2'b10) begin failures++; $display("FAIL prio_load_rvalid got d,i=%b exp=10", {bus1.d_rvalid, bus1.i_rvalid}); end
        checks++; if (bus1.d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL prio_load_rdata got=%h exp=deadbeef", bus1.d_rdata); end
        tick();
        #1;
        checks++; if ({bus1.mem_en, bus1.d_rvalid, bus1.i_rvalid} !== 3'b000) begin
            failures++; $display("FAIL prio_idle got en,d_rv,i_rv=%b exp=000", {bus1.mem_en, bus1.d_rvalid, bus1.i_rvalid});
        end
    endtask

    task automatic test_latency3();
        // Expected per cycle T..T+6: {i_gnt, i_rvalid}; i_req held until its second grant.
        logic [1:0]  exp_tab [0:6];
        logic [31:0] rdata_exp;
        exp_tab[0] = 2'b10; exp_tab[1] = 2'b00; exp_tab[2] = 2'b00; exp_tab[3] = 2'b11;
        exp_tab[4] = 2'b00; exp_tab[5] = 2'b00; exp_tab[6] = 2'b01;
        for (int t = 0; t < 7; t++) begin
            tick();
            bus3.i_req  = (t <= 3);
            bus3.i_addr = (t == 0) ? 32'h10 : 32'h14;
            #1;
            checks++; if ({bus3.i_gnt, bus3.i_rvalid} !== exp_tab[t]) begin
                failures++; $display("FAIL lat3 t=%0d got gnt,rvalid=%b exp=%b", t, {bus3.i_gnt, bus3.i_rvalid}, exp_tab[t]);
            end
            if (t == 1 || t == 2) begin
                checks++; if (bus3.mem_en !== 1'b0 || bus3.mem_addr !== 32'h0) begin
                    failures++; $display("FAIL lat3_busy t=%0d got en=%b addr=%h exp en=0 addr=0", t, bus3.mem_en, bus3.mem_addr);
                end
            end
            if (exp_tab[t][0]) begin
                rdata_exp = (t == 3) ? 32'h10 : 32'h14;
                checks++; if (bus3.i_rdata !== rdata_exp) begin failures++; $display("FAIL lat3_rdata t=%0d got=%h exp=%h", t, bus3.i_rdata, rdata_exp); end
            end
        end
    endtask

    task automatic test_fairness();
        logic exp_i;
        tick();
        bus1.i_req = 1'b1; bus1.i_addr = 32'h20;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h40;
        for (int k = 0; k < 20; k++) begin
`ifdef ARB_FAIRNESS_EN
            exp_i = ((k % 5) == 4);
`else
            exp_i = 1'b0;
`endif
            #1;
            checks++; if ({bus1.d_gnt, bus1.i_gnt} !== {!exp_i, exp_i}) begin
                failures++; $display("FAIL fair k=%0d got d,i=%b exp=%b", k, {bus1.d_gnt, bus1.i_gnt}, {!exp_i, exp_i});
            end
            tick();
        end
        bus1.i_req = 1'b0;
        bus1.d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_wait();
        tick();
        bus3.i_req = 1'b1; bus3.i_addr = 32'h8;
        #1;
        checks++; if (bus3.i_gnt !== 1'b1) begin failures++; $display("FAIL rw_gnt got=%b exp=1", bus3.i_gnt); end
        tick();
        bus3.i_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks++; if ({bus3.i_rvalid, bus3.mem_en, bus3.i_rdata} !== 34'h0) begin
            failures++; $display("FAIL rw_in_reset got rvalid=%b en=%b rdata=%h exp all 0", bus3.i_rvalid, bus3.mem_en, bus3.i_rdata);
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus3.i_rvalid !== 1'b0) begin failures++; $display("FAIL rw_no_rvalid cyc=%0d got=%b exp=0", c, bus3.i_rvalid); end
            tick();
        end
        bus3.i_req = 1'b1; bus3.i_addr = 32'hC;
        #1;
        checks++; if (bus3.i_gnt !== 1'b1) begin failures++; $display("FAIL rw_idle_gnt got=%b exp=1", bus3.i_gnt); end
        tick();
        bus3.i_req = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (bus3.i_rvalid !== 1'b1 || bus3.i_rdata !== 32'hC) begin
            failures++; $display("FAIL rw_after got rvalid=%b rdata=%h exp rvalid=1 rdata=c", bus3.i_rvalid, bus3.i_rdata);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_wstrb = '0;
        bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        bus3.d_addr = '0; bus3.d_wdata = '0; bus3.d_wstrb = '0;
        @(negedge clk);
        test_reset();
        test_fetch_stream();
        test_priority();
        test_latency3();
        test_fairness();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
